// File: rtl/rf_defs.sv
// Shared register-file constants for the NPC core's decode and writeback stages.
package rf_defs;

  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned REG_ZERO       = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared at writeback, issue wins on a tie.
module rf_scoreboard
  import rf_defs::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NW         = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iss_en,
  input  logic [ADDR_WIDTH-1:0]      iss_addr,
  input  logic [NW-1:0]              we,
  input  logic [NW*ADDR_WIDTH-1:0]   wa,
  output logic [2**ADDR_WIDTH-1:0]   busy
);

  localparam int unsigned NREGS = 2**ADDR_WIDTH;

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] set_v, clr_v;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (iss_en) begin
      set_v[iss_addr] = 1'b1;
    end
    for (int j = 0; j < NW; j++) begin
      if (we[j]) begin
        clr_v[wa[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
      end
    end
    // A new producer issuing in the old producer's writeback cycle keeps the bit set.
    busy_d           = set_v | (busy_q & ~clr_v);
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-first bypass, hardwired x0 and busy scoreboard.
module regfile_mp
  import rf_defs::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NR         = 2,
  parameter int unsigned NW         = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NR*ADDR_WIDTH-1:0]   ra,
  output logic [NR*DATA_WIDTH-1:0]   rd,
  output logic [NR-1:0]              rbusy,
  input  logic [NW-1:0]              we,
  input  logic [NW*ADDR_WIDTH-1:0]   wa,
  input  logic [NW*DATA_WIDTH-1:0]   wd,
  input  logic                       iss_en,
  input  logic [ADDR_WIDTH-1:0]      iss_addr
);

  localparam int unsigned          NREGS     = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [NREGS-1:0]      busy;

  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NW         (NW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .we       (we),
    .wa       (wa),
    .busy     (busy)
  );

  // Ports are visited in ascending order, so the highest-index port wins an address conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (we[j] && wa[j*ADDR_WIDTH +: ADDR_WIDTH] != ZERO_ADDR) begin
          regs_q[wa[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wd[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;

    assign addr = ra[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      data = regs_q[addr];
      for (int j = 0; j < NW; j++) begin
        if (we[j] && wa[j*ADDR_WIDTH +: ADDR_WIDTH] == addr) begin
          data = wd[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (rst || addr == ZERO_ADDR) begin
        data = '0;
      end
    end

    assign rd[i*DATA_WIDTH +: DATA_WIDTH] = data;
    // Registered busy only: decode stalls one cycle conservatively instead of looping through issue.
    assign rbusy[i] = ~rst & busy[addr];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp against a plain array-based reference model.
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;
  localparam int NW = 2;
  localparam int NREGS = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  ra;
  logic [NR*DW-1:0]  rd;
  logic [NR-1:0]     rbusy;
  logic [NW-1:0]     we;
  logic [NW*AW-1:0]  wa;
  logic [NW*DW-1:0]  wd;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [DW-1:0] m_regs [NREGS];
  logic          m_busy [NREGS];

  regfile_mp #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NR         (NR),
    .NW         (NW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ra       (ra),
    .rd       (rd),
    .rbusy    (rbusy),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .iss_en   (iss_en),
    .iss_addr (iss_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required end before 2000000)", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] get_rd(input int i);
    return rd[i*DW +: DW];
  endfunction

  // Reference model step: applies the currently driven inputs as the next posedge would.
  task automatic cycle();
    int a;
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int j = 0; j < NW; j++) begin
        a = int'(wa[j*AW +: AW]);
        if (we[j]) begin
          if (a != 0) m_regs[a] = wd[j*DW +: DW];
          m_busy[a] = 1'b0;
        end
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; we = '0; wa = '0; wd = '0; iss_en = 1'b0; iss_addr = '0; ra = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; we = 2'b01; wa = 10'd3; wd = 64'hFFFF; iss_en = 1'b1; iss_addr = 5'd3;
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < NREGS; a += 3) begin
        ra = {5'(a), 5'(a), 5'(a)};
        #1;
        total_cnt++;
        if (rd !== '0 || rbusy !== '0)
          $display("FAIL reset_hold addr %0d: rd=%h rbusy=%b, required rd=0 rbusy=0", a, rd, rbusy);
        else pass_cnt++;
      end
      cycle();
    end
    idle();
    ra = {5'd3, 5'd3, 5'd3};
    #1;
    total_cnt++;
    if (get_rd(0) !== 32'h0 || rbusy[0] !== 1'b0)
      $display("FAIL reset_release r3: rd=%h rbusy=%b, required 0 and 0", get_rd(0), rbusy[0]);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    idle();
    we = 2'b01; wa = 10'd5; wd = 64'h1234; ra[AW-1:0] = 5'd5;
    #1;
    total_cnt++;
    if (get_rd(0) !== 32'h1234) $display("FAIL bypass_same_cycle: rd0=%h, required 1234", get_rd(0));
    else pass_cnt++;
    cycle();
    we = '0;
    #1;
    total_cnt++;
    if (get_rd(0) !== 32'h1234) $display("FAIL write_next_cycle: rd0=%h, required 1234", get_rd(0));
    else pass_cnt++;
  endtask

  task automatic test_x0();
    idle();
    we = 2'b01; wa = 10'd0; wd = 64'hDEAD; iss_en = 1'b1; iss_addr = 5'd0;
    #1;
    total_cnt++;
    if (get_rd(0) !== 32'h0 || rbusy[0] !== 1'b0)
      $display("FAIL x0_write_cycle: rd0=%h rbusy0=%b, required 0 and 0", get_rd(0), rbusy[0]);
    else pass_cnt++;
    cycle();
    we = '0; iss_en = 1'b0;
    #1;
    total_cnt++;
    if (get_rd(0) !== 32'h0 || rbusy[0] !== 1'b0)
      $display("FAIL x0_after: rd0=%h rbusy0=%b, required 0 and 0", get_rd(0), rbusy[0]);
    else pass_cnt++;
  endtask

  task automatic test_conflict();
    idle();
    we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'hBBBB, 32'hAAAA}; ra[AW-1:0] = 5'd7;
    #1;
    total_cnt++;
    if (get_rd(0) !== 32'hBBBB) $display("FAIL conflict_bypass: rd0=%h, required bbbb", get_rd(0));
    else pass_cnt++;
    cycle();
    we = '0;
    #1;
    total_cnt++;
    if (get_rd(0) !== 32'hBBBB) $display("FAIL conflict_stored: rd0=%h, required bbbb", get_rd(0));
    else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    logic exp_b [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    idle();
    ra[AW-1:0] = 5'd9;
    for (int c = 0; c < 6; c++) begin
      iss_en = (c == 0); iss_addr = 5'd9;
      we = (c == 3) ? 2'b01 : 2'b00; wa = 10'd9; wd = 64'h99;
      #1;
      total_cnt++;
      if (rbusy[0] !== exp_b[c])
        $display("FAIL scoreboard cycle %0d: rbusy0=%b, required %b", c, rbusy[0], exp_b[c]);
      else pass_cnt++;
      cycle();
    end
    iss_en = 1'b1; we = '0;
    cycle();
    iss_en = 1'b1; we = 2'b10; wa = {5'd9, 5'd0};
    cycle();
    idle();
    ra[AW-1:0] = 5'd9;
    #1;
    total_cnt++;
    if (rbusy[0] !== 1'b1) $display("FAIL set_beats_clear: rbusy0=%b, required 1", rbusy[0]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int a;
    logic [DW-1:0] e;
    logic eb;
    for (int c = 0; c < 10000; c++) begin
      rst = 1'b0;
      we = 2'($urandom_range(0, 3));
      wa = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      wd = {32'($urandom), 32'($urandom)};
      iss_en = 1'($urandom_range(0, 1));
      iss_addr = 5'($urandom_range(0, 31));
      for (int i = 0; i < NR; i++) ra[i*AW +: AW] = 5'($urandom_range(0, 31));
      if (c % 4 == 0) ra[AW +: AW] = wa[AW +: AW];
      #1;
      for (int i = 0; i < NR; i++) begin
        a = int'(ra[i*AW +: AW]);
        e = m_regs[a];
        for (int j = 0; j < NW; j++)
          if (we[j] && int'(wa[j*AW +: AW]) == a) e = wd[j*DW +: DW];
        if (a == 0) e = '0;
        eb = (a == 0) ? 1'b0 : m_busy[a];
        total_cnt++;
        if (get_rd(i) !== e || rbusy[i] !== eb)
          $display("FAIL random c%0d port%0d addr%0d: rd=%h rbusy=%b, required rd=%h rbusy=%b",
                   c, i, a, get_rd(i), rbusy[i], e, eb);
        else pass_cnt++;
      end
      cycle();
    end
    rst = 1'b1;
    cycle();
    idle();
    for (int i = 0; i < NR; i++) ra[i*AW +: AW] = 5'($urandom_range(1, 31));
    iss_en = 1'b0;
    #1;
    total_cnt++;
    if (rd !== '0 || rbusy !== '0)
      $display("FAIL random_reset: rd=%h rbusy=%b, required all 0", rd, rbusy);
    else pass_cnt++;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_bypass();
    test_x0();
    test_conflict();
    test_scoreboard();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
